// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN streaming pool stage.
package cnn_pkg;

  typedef enum logic [1:0] {
    MODE_MAX = 2'd0,
    MODE_MIN = 2'd1,
    MODE_AVG = 2'd2
  } pool_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pool_state_t;

  // Accumulator width that holds a full-window signed sum without overflow.
  function automatic int ACC_W(input int wd, input int win_size);
    return wd + $clog2(win_size) + 1;
  endfunction

  // The reserved encoding falls back to max pooling.
  function automatic pool_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_MIN;
      2'd2:    return MODE_AVG;
      default: return MODE_MAX;
    endcase
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// Single-lane pooling accumulator and result register.
// Optional POOL_RELU_FUSE_EN clamps negative results to zero.
module pool_lane
  import cnn_pkg::*;
#(
  parameter int WD        = 16,
  parameter int WIN_SIZE  = 4,
  parameter int AVG_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat_first,
  input  logic                 beat_acc,
  input  logic                 emit,
  input  pool_mode_t           mode,
  input  logic signed [WD-1:0] data,
  output logic signed [WD-1:0] q
);

  localparam int AW = ACC_W(WD, WIN_SIZE);

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x);
    return (x + (64'sd1 <<< (AVG_SHIFT - 1))) >>> AVG_SHIFT;
  endfunction

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] data_x;
  logic signed [63:0]   wide;
  logic signed [63:0]   res;

  always_comb begin
    data_x  = {{(AW-WD){data[WD-1]}}, data};
    acc_nxt = data_x;
    if (!beat_first) begin
      case (mode)
        MODE_MIN: acc_nxt = (data_x < acc) ? data_x : acc;
        MODE_AVG: acc_nxt = acc + data_x;
        default:  acc_nxt = (data_x > acc) ? data_x : acc;
      endcase
    end
    wide = {{(64-AW){acc_nxt[AW-1]}}, acc_nxt};
    if (mode == MODE_AVG) res = sat_signed(round_shift(wide), WD);
    else                  res = wide;
`ifdef POOL_RELU_FUSE_EN
    if (res < 64'sd0) res = 64'sd0;
`endif
  end

  // Result stage: q is loaded on the accepted last beat of a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
    end else begin
      if (beat_first || beat_acc) acc <= acc_nxt;
      if (emit)                   q   <= res[WD-1:0];
    end
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming window pool (max/min/avg) over CH_NUM signed lanes, valid/ready framed.
// Optional POOL_RELU_FUSE_EN fuses a relu clamp into each lane result.
module pool_stream
  import cnn_pkg::*;
#(
  parameter int CH_NUM    = 6,
  parameter int WD        = 16,
  parameter int WIN_SIZE  = 4,
  parameter int AVG_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 first_data,
  input  logic                 last_data,
  input  logic [WD*CH_NUM-1:0] data_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WD*CH_NUM-1:0] q,
  output logic                 err
);

  localparam int CW = $clog2(WIN_SIZE + 1);

  pool_state_t state;
  logic [CW-1:0] cnt;
  pool_mode_t  mode_q;
  pool_mode_t  eff_mode;
  logic        accept;
  logic        beat_first;
  logic        beat_acc;
  logic        beat_stray;
  logic        emit;

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    accept     = in_valid && in_ready;
    beat_first = accept && first_data;
    beat_acc   = accept && !first_data && (state == ST_ACC);
    beat_stray = accept && !first_data && (state == ST_IDLE);
    emit       = (beat_first || beat_acc) && last_data;
    // The window's mode is taken from its first beat and held thereafter.
    eff_mode   = first_data ? decode_mode(mode) : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      mode_q    <= MODE_MAX;
    end else begin
      err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (emit)                   out_valid <= 1'b1;
      if (beat_first) begin
        mode_q <= eff_mode;
        cnt    <= CW'(1);
        state  <= last_data ? ST_IDLE : ST_ACC;
        if ((state == ST_ACC) || (last_data && (WIN_SIZE != 1))) err <= 1'b1;
      end else if (beat_acc) begin
        cnt <= cnt + CW'(1);
        if (last_data) begin
          state <= ST_IDLE;
          if ((32'(cnt) + 32'd1) != 32'(WIN_SIZE)) err <= 1'b1;
        end
      end else if (beat_stray) begin
        err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    pool_lane #(
      .WD        (WD),
      .WIN_SIZE  (WIN_SIZE),
      .AVG_SHIFT (AVG_SHIFT)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .beat_first (beat_first),
      .beat_acc   (beat_acc),
      .emit       (emit),
      .mode       (eff_mode),
      .data       (data_i[WD*(CH_NUM-k)-1 -: WD]),
      .q          (q[WD*(CH_NUM-k)-1 -: WD])
    );
  end

endmodule

// File: tb/tb_pool_stream.sv
// Self-checking bench for pool_stream: directed and random windows against a list-based model.
module tb_pool_stream;

  localparam int CH_NUM    = 6;
  localparam int WD        = 16;
  localparam int WIN_SIZE  = 4;
  localparam int AVG_SHIFT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic                 first_data;
  logic                 last_data;
  logic [WD*CH_NUM-1:0] data_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [WD*CH_NUM-1:0] q;
  logic                 err;

  int checks = 0;
  int errors = 0;
  int win [0:7][0:CH_NUM-1];

  pool_stream #(
    .CH_NUM    (CH_NUM),
    .WD        (WD),
    .WIN_SIZE  (WIN_SIZE),
    .AVG_SHIFT (AVG_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .first_data (first_data),
    .last_data  (last_data),
    .data_i     (data_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD-1:0] q_lane(input int k);
    return q[WD*(CH_NUM-k)-1 -: WD];
  endfunction

  // Reference: reduce the beat list lo..hi of lane k by the window's mode.
  function automatic int model(input int m, input int k, input int lo, input int hi);
    int r;
    int s;
    int d;
    r = win[lo][k];
    s = 0;
    for (int i = lo; i <= hi; i++) begin
      s += win[i][k];
      if (m == 1) r = (win[i][k] < r) ? win[i][k] : r;
      else        r = (win[i][k] > r) ? win[i][k] : r;
    end
    if (m == 2) begin
      d = 2 ** AVG_SHIFT;
      r = int'($floor((real'(s) + real'(d) / 2.0) / real'(d)));
      if (r > 2 ** (WD - 1) - 1) r = 2 ** (WD - 1) - 1;
      if (r < -(2 ** (WD - 1)))  r = -(2 ** (WD - 1));
    end
`ifdef POOL_RELU_FUSE_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic rand_win(input int lo, input int hi);
    logic signed [WD-1:0] t;
    for (int i = lo; i <= hi; i++)
      for (int k = 0; k < CH_NUM; k++) begin
        t = WD'($urandom);
        win[i][k] = int'(t);
      end
  endtask

  task automatic load_data(input int b);
    for (int k = 0; k < CH_NUM; k++) data_i[WD*(CH_NUM-k)-1 -: WD] = WD'(win[b][k]);
  endtask

  task automatic drive(input bit f, input bit l, input int m, input int b, output bit e);
    in_valid = 1'b1; first_data = f; last_data = l; mode = 2'(m);
    load_data(b);
    @(posedge clk); #1;
    e = err;
    in_valid = 1'b0; first_data = 1'b0; last_data = 1'b0;
  endtask

  task automatic check_window(input string tag, input int m, input int lo, input int hi);
    int e;
    logic [WD-1:0] e16;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    for (int k = 0; k < CH_NUM; k++) begin
      e   = model(m, k, lo, hi);
      e16 = e[WD-1:0];
      check($sformatf("%s_lane%0d", tag, k), 32'(q_lane(k)), 32'(e16));
    end
  endtask

  // Full legal window from win[lo..lo+WIN_SIZE-1]; later beats carry a random (ignored) mode.
  task automatic send_full(input string tag, input int m, input int lo);
    bit e;
    for (int i = 0; i < WIN_SIZE; i++) begin
      drive(i == 0, i == WIN_SIZE - 1, (i == 0) ? m : int'($urandom_range(0, 3)), lo + i, e);
      check($sformatf("%s_err%0d", tag, i), 32'(e), 32'd0);
      if (i == WIN_SIZE - 2) check({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    check_window(tag, m, lo, lo + WIN_SIZE - 1);
  endtask

  initial begin
    bit e;
    int exp_relu;
    logic [WD-1:0] hold0;
    logic [WD-1:0] hold5;
    logic [WD-1:0] e16;

    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; first_data = 1'b0; last_data = 1'b0;
    data_i = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_q", 32'(q == '0), 32'd1);
    rst = 1'b0;

    // MAX with the directed lane values
    rand_win(0, 3);
    win[0][0] = 3;  win[1][0] = -7; win[2][0] = 12; win[3][0] = 5;
    win[0][1] = -1; win[1][1] = -2; win[2][1] = -3; win[3][1] = -4;
    send_full("max", 0, 0);
    check("max_lane0_const", 32'(q_lane(0)), 32'd12);

    // AVG with rounding, negatives and extreme values
    rand_win(0, 3);
    for (int i = 0; i < 4; i++) begin
      win[i][0] = i + 1;
      win[i][1] = -(i + 1);
      win[i][2] = 32767;
      win[i][3] = -32768;
    end
    send_full("avg", 2, 0);

    rand_win(0, 3);
    send_full("min", 1, 0);
    rand_win(0, 3);
    send_full("mode3", 3, 0);

    repeat (12) begin
      rand_win(0, 3);
      send_full("rand", int'($urandom_range(0, 3)), 0);
    end

    // Backpressure: result must hold and no beat may enter while stalled
    @(posedge clk); #1;
    rand_win(0, 7);
    out_ready = 1'b0;
    send_full("bp", 0, 0);
    e16 = 16'(model(0, 0, 0, 3)); hold0 = e16;
    e16 = 16'(model(0, 5, 0, 3)); hold5 = e16;
    in_valid = 1'b1; first_data = 1'b1; mode = 2'd2; load_data(4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_hold", 32'({q_lane(0), q_lane(5)}), 32'({hold0, hold5}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_err", 32'(err), 32'd0);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0; first_data = 1'b0;
    drive(0, 0, 0, 5, e);
    drive(0, 0, 1, 6, e);
    drive(0, 1, 0, 7, e);
    check("bp2_err", 32'(e), 32'd0);
    check_window("bp2", 2, 4, 7);

    // Short window: error pulse but result still emitted
    rand_win(0, 2);
    drive(1, 0, 0, 0, e); check("short_err0", 32'(e), 32'd0);
    drive(0, 0, 0, 1, e); check("short_err1", 32'(e), 32'd0);
    drive(0, 1, 0, 2, e); check("short_err2", 32'(e), 32'd1);
    check_window("short", 0, 0, 2);

    // first_data mid-window restarts the window
    rand_win(0, 5);
    drive(1, 0, 1, 0, e);
    drive(0, 0, 1, 1, e);
    drive(1, 0, 1, 2, e); check("restart_err", 32'(e), 32'd1);
    drive(0, 0, 0, 3, e); check("restart_err_clr", 32'(e), 32'd0);
    drive(0, 0, 2, 4, e);
    drive(0, 1, 0, 5, e); check("restart_last_err", 32'(e), 32'd0);
    check_window("restart", 1, 2, 5);

    // Stray beats in IDLE are dropped
    drive(0, 0, 0, 0, e);
    check("stray_err", 32'(e), 32'd1);
    check("stray_valid", 32'(out_valid), 32'd0);
    drive(0, 1, 0, 1, e);
    check("stray_last_err", 32'(e), 32'd1);
    check("stray_last_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("err_pulse_width", 32'(err), 32'd0);

    // Reset mid-window discards the partial window
    rand_win(0, 3);
    drive(1, 0, 2, 0, e);
    drive(0, 0, 2, 1, e);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    rand_win(0, 3);
    send_full("after_rst", 2, 0);

    // Reset with a stalled result pending
    @(posedge clk); #1;
    out_ready = 1'b0;
    rand_win(0, 3);
    send_full("pend", 0, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("pend_rst_valid", 32'(out_valid), 32'd0);
    check("pend_rst_q", 32'(q == '0), 32'd1);
    out_ready = 1'b1;
    rand_win(0, 3);
    send_full("after_rst2", 1, 0);

    // MIN on a negative minimum (relu clamp when fused)
    rand_win(0, 3);
    win[0][0] = -5; win[1][0] = 4; win[2][0] = 2; win[3][0] = 1;
    send_full("min_relu", 1, 0);
`ifdef POOL_RELU_FUSE_EN
    exp_relu = 0;
`else
    exp_relu = -5;
`endif
    e16 = exp_relu[WD-1:0];
    check("min_relu_const", 32'(q_lane(0)), 32'(e16));

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Parametrised successor to the fixed max-pool stage.
- Reduces a stream of pooling-window beats, framed by first/last markers from the window iterator, into one result per window.
- Each beat carries CH_NUM parallel signed channels. Reduction mode is max, min or average, selectable per window.
- Valid/ready handshake on input and output; sits between relu/conv output and the next conv layer's buffer.

Parameters:
- CH_NUM, 6, number of parallel channel lanes.
- WD, 16, signed data width per lane.
- WIN_SIZE, 4, beats per window (KERNEL_SIZEX*KERNEL_SIZEY of the pool).
- AVG_SHIFT, 2, right shift applied in AVG mode (divide by 2**AVG_SHIFT). Must be >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- mode  in  2  0=MAX, 1=MIN, 2=AVG, 3=reserved (treated as MAX). Sampled on the accepted first beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- first_data  in  1  beat is first of window.
- last_data  in  1  beat is last of window.
- data_i  in  WD*CH_NUM  lane k at bits [WD*(CH_NUM-k)-1 -: WD]; lane 0 is MSB.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- q  out  WD*CH_NUM  result, same lane packing.
- err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset, clock and reset handling: one clock `clk`; reset `rst` is synchronous and active high. Reset values: out_valid=0, q=0, err=0, state=IDLE, beat counter=0, accumulators=0, latched mode=MAX.
- in_ready = !out_valid || out_ready (combinational). No beat is accepted while a result is stalled.
- Beat counter cnt, width clog2(WIN_SIZE+1):
  - Accepted first_data sets cnt=1.
  - Each other accepted beat in ACC state increments cnt.
- States:
  - IDLE -> ACC on an accepted beat with first_data=1 and last_data=0.
  - IDLE -> IDLE with a result produced when first_data=1 and last_data=1 (legal only if WIN_SIZE==1).
  - ACC -> IDLE on an accepted last_data beat.
- Per-lane accumulation:
  - On first beat: acc=data.
  - Afterwards: MAX acc=max(acc,data), MIN acc=min(acc,data), AVG acc=acc+data. All compares and sums are signed.
  - Accumulator width WD+clog2(WIN_SIZE)+1; no overflow is possible.
- Result, registered on the accepted last beat (data of that beat included). out_valid rises the next cycle, so latency is 1 clk from the last beat to out_valid.
  - MAX/MIN: result is the accumulator value.
  - AVG: result = (acc + 2**(AVG_SHIFT-1)) >>> AVG_SHIFT, saturated to the signed WD range.
- Output hold: q and out_valid hold until out_valid&out_ready. Accept and new-result load may happen in the same cycle (throughput 1 window per WIN_SIZE beats, no bubble).
- Framing errors (err pulses one cycle after the offending beat):
  - Beat without first_data in IDLE: beat dropped.
  - first_data while in ACC: window restarts with this beat; the partial window is discarded.
  - last_data with cnt+1 != WIN_SIZE: result still emitted.
- Reset mid-window: the partial window is discarded and any pending out_valid is cleared.
- Mode changes mid-window are ignored (the latched mode is used).

Optional Feature:
- Macro POOL_RELU_FUSE_EN.
- Defined: each lane's result is clamped to 0 when negative, after rounding and saturation. This fuses the relu stage and removes one pipeline stage from the layer.
- Undefined: result passes unmodified; behaviour is exactly as above.

Decomposition:
- Package cnn_pkg holds:
  - pool_mode_t enum: MODE_MAX=0, MODE_MIN=1, MODE_AVG=2.
  - function clog2-based ACC_W(WD,WIN_SIZE).
  - Saturation helper function sat_signed.
- Sub-module pool_lane is the single-lane accumulator plus result logic. It is generated CH_NUM times.
- Control (FSM, counter, handshake, err) stays in pool_stream.

Test Plan:
- MAX, CH_NUM=2, WIN_SIZE=4, beats lane0 {3,-7,12,5}, lane1 {-1,-2,-3,-4}, out_ready=1 -> q lane0=12, lane1=-1, out_valid 1 clk after last beat.
- AVG, AVG_SHIFT=2, lane0 beats {1,2,3,4} -> (10+2)>>>2=3. Lane1 beats {-1,-2,-3,-4} -> (-10+2)>>>2=-2. Lane with all 32767 -> 32767 (no overflow).
- Backpressure: hold out_ready=0 after first result -> in_ready=0, q stable for 10 clks. Release -> next window accepted the same cycle out_ready=1.
- Framing errors:
  - 3-beat window with last on beat 3 -> err pulse, result emitted.
  - first_data mid-window -> err pulse, result covers only the new window.
  - Stray beat in IDLE -> err, no output.
- Reset mid-window after 2 beats and with out_valid pending -> out_valid=0, next full window gives a correct result.
- POOL_RELU_FUSE_EN defined, MIN mode on {-5,4,2,1} -> q=0. Undefined -> q=-5.
